servo_pwm_gen: RTL and testbench

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

---
 rtl/servo_pwm_gen.sv | 103 ++++++++++
 tb/tb_servo_pwm_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// ============================================================================
// Module   : servo_pwm_gen
// Brief    : Hobby-servo PWM frame generator; latches a commanded angle once
//            per frame and emits a MIN_PULSE + angle*STEP_CYC wide pulse.
//            Optional macro SERVO_ANGLE_CLAMP_EN limits the latched angle to 180.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_pwm_gen #(
    parameter int PERIOD_CYC = 1000000,
    parameter int MIN_PULSE  = 25000,
    parameter int STEP_CYC   = 556
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEn,
    input  logic [7:0] iAngle,
    output logic       oPwm,
    output logic       oFrame,
    output logic       oBusy
);

    localparam int CNT_W  = $clog2(PERIOD_CYC);
    // Width arithmetic is carried in at least 20 bits so the full product fits.
    localparam int CALC_W = (CNT_W > 20) ? CNT_W : 20;

    localparam logic [1:0] cIdle = 2'd0;
    localparam logic [1:0] cHigh = 2'd1;
    localparam logic [1:0] cLow  = 2'd2;

    localparam logic [7:0]       cResetAngle = 8'd90;
    localparam logic [CNT_W-1:0] cLastCnt    = CNT_W'(PERIOD_CYC - 1);

    logic [1:0]        rState;
    logic [CNT_W-1:0]  rCnt;
    logic [7:0]        rAngle;
    logic              rPwm;
    logic              rFrame;
    logic              rBusy;

    logic [7:0]        wAngleIn;
    logic [CALC_W-1:0] wWidth;
    logic [CALC_W-1:0] wWidthM1;
    logic              wPulseEnd;
    logic              wFrameEnd;
    logic              wLatch;

`ifdef SERVO_ANGLE_CLAMP_EN
    assign wAngleIn = (iAngle > 8'd180) ? 8'd180 : iAngle;
`else
    assign wAngleIn = iAngle;
`endif

    assign wWidth    = CALC_W'(MIN_PULSE) + (CALC_W'(rAngle) * CALC_W'(STEP_CYC));
    assign wWidthM1  = wWidth - CALC_W'(1);
    assign wPulseEnd = (CALC_W'(rCnt) == wWidthM1);
    assign wFrameEnd = (rCnt == cLastCnt);

    // A new frame starts from IDLE, or back-to-back on the last cycle of a frame.
    assign wLatch = iEn && ((rState == cIdle) || wFrameEnd);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rState <= cIdle;
            rCnt   <= '0;
            rAngle <= cResetAngle;
            rPwm   <= 1'b0;
            rFrame <= 1'b0;
            rBusy  <= 1'b0;
        end else begin
            rFrame <= 1'b0;
            if (wLatch) begin
                rAngle <= wAngleIn;
                rCnt   <= '0;
                rState <= cHigh;
                rPwm   <= 1'b1;
                rFrame <= 1'b1;
                rBusy  <= 1'b1;
            end else if (rState != cIdle) begin
                if (wFrameEnd) begin
                    rState <= cIdle;
                    rCnt   <= '0;
                    rPwm   <= 1'b0;
                    rBusy  <= 1'b0;
                end else begin
                    rCnt <= rCnt + CNT_W'(1);
                    if ((rState == cHigh) && wPulseEnd) begin
                        rState <= cLow;
                        rPwm   <= 1'b0;
                    end
                end
            end
        end
    end

    assign oPwm   = rPwm;
    assign oFrame = rFrame;
    assign oBusy  = rBusy;

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
// ============================================================================
// Module   : tb_servo_pwm_gen
// Brief    : Scoreboard bench for servo_pwm_gen with shortened frame timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_pwm_gen;

    localparam int P    = 600;
    localparam int MINP = 40;
    localparam int STEP = 2;

    typedef struct {
        int width;
        bit last;
    } exp_t;

    logic       iClk;
    logic       iRst_n;
    logic       iEn;
    logic [7:0] iAngle;
    logic       oPwm;
    logic       oFrame;
    logic       oBusy;

    exp_t q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    bit   inFrame = 0;
    bit   abortPending = 0;
    int   pos = 0;
    int   shapeErr = 0;

    servo_pwm_gen #(
        .PERIOD_CYC(P),
        .MIN_PULSE (MINP),
        .STEP_CYC  (STEP)
    ) dut (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .iEn   (iEn),
        .iAngle(iAngle),
        .oPwm  (oPwm),
        .oFrame(oFrame),
        .oBusy (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: pulse width in cycles from the commanded angle.
    function automatic int expWidth(input int angle);
        int a;
        a = angle;
`ifdef SERVO_ANGLE_CLAMP_EN
        if (a > 180) a = 180;
`endif
        return MINP + a * STEP;
    endfunction

    task automatic finalize(input bit endedByFrame);
        if (abortPending) begin
            check("abort_shape", shapeErr, 0);
            abortPending = 0;
        end else begin
            check("frame_len", pos, P);
            check("pulse_shape", shapeErr, 0);
            check("frame_continue", endedByFrame, !cur.last);
        end
        inFrame = 0;
    endtask

    // Monitor: measures every frame the DUT announces and scores it.
    initial begin
        forever begin
            @(posedge iClk);
            #1;
            if (inFrame && (oFrame || !oBusy)) finalize(oFrame);
            if (oFrame) begin
                if (q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    cur      = q.pop_front();
                    inFrame  = 1;
                    pos      = 0;
                    shapeErr = 0;
                end
            end
            if (inFrame) begin
                if (oPwm !== (pos < cur.width)) shapeErr++;
                pos++;
            end
        end
    end

    task automatic runFrame(input int angle, input bit noise, input int stopAt, input int abortAt);
        exp_t e;
        iEn     = 1'b1;
        iAngle  = angle[7:0];
        e.width = expWidth(angle);
        e.last  = (stopAt > 0);
        q.push_back(e);
        for (int i = 1; i <= P; i++) begin
            @(negedge iClk);
            if (abortAt > 0 && i == abortAt) begin
                check("pwm_before_rst", oPwm, 1);
                abortPending = 1;
                iEn    = 1'b0;
                iRst_n = 1'b0;
                #1;
                check("rst_async_pwm", oPwm, 0);
                check("rst_async_busy", oBusy, 0);
                check("rst_async_frame", oFrame, 0);
                repeat (3) @(negedge iClk);
                iRst_n = 1'b1;
                return;
            end
            if (stopAt > 0 && i == stopAt) iEn = 1'b0;
            else if (noise && i < P && $urandom_range(0, 15) == 0) iAngle = 8'($urandom);
        end
    endtask

    initial begin
        iRst_n = 1'b0;
        iEn    = 1'b0;
        iAngle = 8'd0;
        repeat (3) @(negedge iClk);
        check("rst_pwm", oPwm, 0);
        check("rst_frame", oFrame, 0);
        check("rst_busy", oBusy, 0);
        iRst_n = 1'b1;
        repeat (5) @(negedge iClk);
        check("idle_busy", oBusy, 0);

        runFrame(90, 1, 0, 0);
        runFrame(0, 1, 0, 0);
        runFrame(180, 1, 0, 0);
        runFrame(200, 1, 0, 0);
        runFrame(255, 0, 0, 0);
        for (int k = 0; k < 7; k++) runFrame($urandom_range(0, 255), 1, 0, 0);
        runFrame($urandom_range(0, 255), 1, P / 3, 0);

        repeat (50) @(negedge iClk);
        check("idle_after_stop", oBusy, 0);

        runFrame(90, 1, 0, 0);
        runFrame(90, 0, 0, MINP / 2);
        repeat (4) @(negedge iClk);
        runFrame(90, 1, 0, 0);
        runFrame($urandom_range(0, 255), 1, P, 0);

        for (int k = 0; k < 4 * P && (q.size() != 0 || inFrame); k++) @(negedge iClk);
        check("drain_queue", q.size(), 0);
        check("drain_idle", inFrame, 0);
        repeat (P + 10) @(negedge iClk);
        check("final_busy", oBusy, 0);
        check("final_pwm", oPwm, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
